chroma_param_sequencer: RTL and testbench
=========================================

CHROMA_PARAM_SEQUENCER -- requirements
Module: chroma_param_sequencer

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, the number of consecutive stable cycles required to accept a button level change.
REQ-002 SHALL have parameter REP_DELAY, default 32, the cycles from an accepted press to the first auto-repeat step.
REQ-003 SHALL have parameter REP_RATE, default 8, the cycles between subsequent auto-repeat steps.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports btn_up, btn_down and btn_mode, each input, 1 bit: raw asynchronous push-buttons, active-high.
REQ-007 SHALL have port ton, output, 8 bits: chroma tone threshold.
REQ-008 SHALL have port color_l, output, 3 bits: line colour code.
REQ-009 SHALL have port color_p, output, 3 bits: background colour code.
REQ-010 SHALL have port sel, output, 2 bits: the currently selected parameter (00 = TONE, 01 = COLOR_L, 10 = COLOR_P).
REQ-011 SHALL have port upd, output, 1 bit: one-cycle pulse, high in the cycle in which ton, color_l or color_p takes a new value.

Function
REQ-012 SHALL pass each button through a 2-FF synchronizer, then a debouncer; the debounced level flips only after the synchronized value has differed from it for DB_CYCLES consecutive cycles.
REQ-013 SHALL define a press as a 0->1 transition of a debounced level, lasting one cycle.
REQ-014 SHALL implement the selection FSM TONE -> COLOR_L -> COLOR_P -> TONE, advancing one state per mode press; sel is driven directly from the state register.
REQ-015 SHALL, on an up step, increment the selected parameter, saturating at 8'hFF for ton and 3'h7 for the colours.
REQ-016 SHALL, on a down step, decrement the selected parameter, saturating at 0.
REQ-017 SHALL leave the parameter unchanged and keep upd low when a step hits saturation.
REQ-018 SHALL generate one step on an up or down press.
REQ-019 SHALL, while exactly one of up/down stays debounced-high, generate a further step REP_DELAY cycles after the press and then every REP_RATE cycles.
REQ-020 SHALL generate no step and clear the repeat counter while both up and down are debounced-high.
REQ-021 SHALL give a mode press in the same cycle as an up/down step priority: the state advances and the step is discarded.
REQ-022 SHALL, on a mode press while up/down is held, cancel auto-repeat until that button is released and pressed again.
REQ-023 SHALL update the parameter register exactly DB_CYCLES+4 cycles after a clean raw rising edge on btn_up/btn_down, with upd high in that same cycle.
REQ-024 SHALL drive the outputs only from registers, with no combinational path from the buttons.

Reset
REQ-025 SHALL, when reset is high at a clock edge, load ton=8'hA4, color_l=3'h0, color_p=3'h7, sel=TONE and upd=0, and clear all synchronizer, debounce and repeat state to 0.
REQ-026 SHALL give reset priority over all events; a button held through reset deasserting yields one press DB_CYCLES+2 cycles after release.

Structure
REQ-027 SHALL define the selection-state encoding, reset values (8'hA4, 3'h0, 3'h7) and saturation limits in the shared package chroma_pkg.
REQ-028 SHALL implement synchronizer plus debouncer as sub-module button_debounce (parameter DB_CYCLES), instantiated three times.

Verification
REQ-029 SHALL verify: reset asserted 1 cycle -> ton=A4, color_l=0, color_p=7, sel=00, upd=0.
REQ-030 SHALL verify: in TONE, btn_up high 10 cycles -> ton A4->A5 exactly once, single upd pulse at DB_CYCLES+4.
REQ-031 SHALL verify: btn_up glitch high 3 cycles -> no change, upd never high.
REQ-032 SHALL verify: mode pressed twice (sel=10), btn_down held 60 cycles -> color_p 7->6 at press, 5 at +32, 4 at +40, 3 at +48, 2 at +56.
REQ-033 SHALL verify: ton=FF, up press -> ton stays FF with no upd; btn_up and btn_down pressed together -> no change.
REQ-034 SHALL verify: three mode presses -> sel 00->01->10->00; mode and up pressed in the same cycle -> sel advances, parameter unchanged.

Source files
------------

// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma parameter sequencer: the selection-state
// encoding, parameter reset values and saturation limits.
package chroma_pkg;

  typedef enum logic [1:0] {
    SEL_TONE    = 2'b00,
    SEL_COLOR_L = 2'b01,
    SEL_COLOR_P = 2'b10
  } sel_t;

  localparam logic [7:0] TON_RST     = 8'hA4;
  localparam logic [2:0] COLOR_L_RST = 3'h0;
  localparam logic [2:0] COLOR_P_RST = 3'h7;

  localparam logic [7:0] TON_MAX     = 8'hFF;
  localparam logic [2:0] COLOR_MAX   = 3'h7;

  // Selection order TONE -> COLOR_L -> COLOR_P -> TONE; the unused code recovers to TONE.
  function automatic sel_t sel_next(input sel_t s);
    case (s)
      SEL_TONE:    return SEL_COLOR_L;
      SEL_COLOR_L: return SEL_COLOR_P;
      default:     return SEL_TONE;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a level debouncer. The debounced level
// flips only after the synchronized input has disagreed with it for
// DB_CYCLES consecutive cycles.
module button_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt   <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chroma_param_sequencer.sv
// Three-button parameter editor: mode cycles the selected parameter, up/down
// step it with saturation and auto-repeat while held. All outputs are
// registered; steps and mode advances pass through one decision register so
// a parameter changes DB_CYCLES+4 cycles after a clean raw button edge.
module chroma_param_sequencer
  import chroma_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned REP_DELAY = 32,
  parameter int unsigned REP_RATE  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  output logic [7:0] ton,
  output logic [2:0] color_l,
  output logic [2:0] color_p,
  output logic [1:0] sel,
  output logic       upd
);

  localparam int unsigned RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REP_RATE - 1);

  logic up_lvl, dn_lvl, md_lvl;
  logic up_lvl_d, dn_lvl_d, md_lvl_d;
  logic up_p, dn_p, md_p;

  sel_t state, state_nx;

  logic          step_up_d, step_dn_d, adv_d;
  logic          step_up_q, step_dn_q, adv_q;
  logic          rep_armed, rep_armed_d;
  logic          rep_first, rep_first_d;
  logic [RW-1:0] rep_cnt, rep_cnt_d;

  logic [7:0] ton_d;
  logic [2:0] color_l_d, color_p_d;
  logic       upd_d;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_up),
    .level (up_lvl)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_down),
    .level (dn_lvl)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .level (md_lvl)
  );

  // Remember last cycle's debounced levels to detect 0->1 presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_lvl_d <= 1'b0;
      dn_lvl_d <= 1'b0;
      md_lvl_d <= 1'b0;
    end else begin
      up_lvl_d <= up_lvl;
      dn_lvl_d <= dn_lvl;
      md_lvl_d <= md_lvl;
    end
  end

  assign up_p = up_lvl & ~up_lvl_d;
  assign dn_p = dn_lvl & ~dn_lvl_d;
  assign md_p = md_lvl & ~md_lvl_d;

  // Selection state register; sel is a direct copy of it.
  always_ff @(posedge clk) begin
    if (reset) state <= SEL_TONE;
    else       state <= state_nx;
  end

  // Advance the selection on a registered mode press.
  always_comb begin
    state_nx = state;
    if (adv_q) state_nx = sel_next(state);
  end

  assign sel = state;

  // Decide this cycle's step/advance and the auto-repeat bookkeeping. A mode
  // press wins over any coincident step and disarms repeat until a new press.
  always_comb begin
    step_up_d   = 1'b0;
    step_dn_d   = 1'b0;
    adv_d       = md_p;
    rep_armed_d = rep_armed;
    rep_first_d = rep_first;
    rep_cnt_d   = rep_cnt;
    if (up_lvl && dn_lvl) begin
      rep_armed_d = 1'b0;
      rep_cnt_d   = '0;
    end else if ((up_p || dn_p) && !md_p) begin
      step_up_d   = up_p;
      step_dn_d   = dn_p;
      rep_armed_d = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (md_p || !(up_lvl || dn_lvl)) begin
      rep_armed_d = 1'b0;
      rep_cnt_d   = '0;
    end else if (rep_armed) begin
      if (rep_cnt == (rep_first ? DLY_LAST : RATE_LAST)) begin
        step_up_d   = up_lvl;
        step_dn_d   = dn_lvl;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d   = rep_cnt + 1'b1;
      end
    end
  end

  // Register the decisions and repeat state.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      adv_q     <= 1'b0;
      rep_armed <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      adv_q     <= adv_d;
      rep_armed <= rep_armed_d;
      rep_first <= rep_first_d;
      rep_cnt   <= rep_cnt_d;
    end
  end

  // Apply a registered step to the selected parameter with saturation.
  always_comb begin
    ton_d     = ton;
    color_l_d = color_l;
    color_p_d = color_p;
    upd_d     = 1'b0;
    if (step_up_q) begin
      case (state)
        SEL_TONE:    if (ton != TON_MAX)       begin ton_d     = ton + 8'd1;     upd_d = 1'b1; end
        SEL_COLOR_L: if (color_l != COLOR_MAX) begin color_l_d = color_l + 3'd1; upd_d = 1'b1; end
        SEL_COLOR_P: if (color_p != COLOR_MAX) begin color_p_d = color_p + 3'd1; upd_d = 1'b1; end
        default: ;
      endcase
    end else if (step_dn_q) begin
      case (state)
        SEL_TONE:    if (ton != '0)     begin ton_d     = ton - 8'd1;     upd_d = 1'b1; end
        SEL_COLOR_L: if (color_l != '0) begin color_l_d = color_l - 3'd1; upd_d = 1'b1; end
        SEL_COLOR_P: if (color_p != '0) begin color_p_d = color_p - 3'd1; upd_d = 1'b1; end
        default: ;
      endcase
    end
  end

  // Parameter registers and update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ton     <= TON_RST;
      color_l <= COLOR_L_RST;
      color_p <= COLOR_P_RST;
      upd     <= 1'b0;
    end else begin
      ton     <= ton_d;
      color_l <= color_l_d;
      color_p <= color_p_d;
      upd     <= upd_d;
    end
  end

endmodule

// File: tb/tb_chroma_param_sequencer.sv
// Self-checking bench for chroma_param_sequencer: directed timing sequences,
// a table of button actions with hand-derived end states, and randomized
// button activity compared every cycle against a cycle-distance model.
module tb_chroma_param_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 32;
  localparam int unsigned RR = 8;

  logic       clk;
  logic       reset;
  logic       btn_up, btn_down, btn_mode;
  logic [7:0] ton;
  logic [2:0] color_l, color_p;
  logic [1:0] sel;
  logic       upd;

  chroma_param_sequencer #(
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_RATE  (RR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_mode (btn_mode),
    .ton      (ton),
    .color_l  (color_l),
    .color_p  (color_p),
    .sel      (sel),
    .upd      (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [DB+1:0] m_hist [3];
  bit            m_lvl  [3];
  bit            p_up   [4];
  bit            p_dn   [4];
  bit            p_adv  [4];
  int            m_cycle;
  int            hold_t;
  int            m_ton, m_cl, m_cp, m_sel;
  bit            m_upd;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = '0;
      m_lvl[b]  = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      p_up[i] = 0; p_dn[i] = 0; p_adv[i] = 0;
    end
    m_cycle = 0;
    hold_t  = -1;
    m_ton   = 'hA4;
    m_cl    = 0;
    m_cp    = 7;
    m_sel   = 0;
    m_upd   = 0;
  endtask

  task automatic model_step(input int dir);
    int v, lim;
    v   = (m_sel == 0) ? m_ton : (m_sel == 1) ? m_cl : m_cp;
    lim = (m_sel == 0) ? 255 : 7;
    if (dir > 0 && v < lim) begin v++; m_upd = 1; end
    if (dir < 0 && v > 0)   begin v--; m_upd = 1; end
    if (m_sel == 0) m_ton = v;
    else if (m_sel == 1) m_cl = v;
    else m_cp = v;
  endtask

  // One rising edge: apply effects decided two cycles ago, debounce the raw
  // samples seen at this edge, then schedule the consequences of presses/holds.
  task automatic model_edge();
    int j, k;
    bit raw [3];
    bit pr  [3];
    bit diff;
    m_cycle++;
    j = m_cycle % 4;
    m_upd = 0;
    if (p_adv[j]) m_sel = (m_sel + 1) % 3;
    if (p_up[j]) model_step(1);
    else if (p_dn[j]) model_step(-1);
    p_up[j] = 0; p_dn[j] = 0; p_adv[j] = 0;

    raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_mode;
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][DB:0], raw[b]};
      diff = 1;
      for (int q = 2; q <= DB + 1; q++)
        if (m_hist[b][q] == m_lvl[b]) diff = 0;
      pr[b] = diff && !m_lvl[b];
      if (diff) m_lvl[b] = !m_lvl[b];
    end

    j = (m_cycle + 2) % 4;
    if (pr[2]) begin
      p_adv[j] = 1;
      hold_t = -1;
    end else if (m_lvl[0] && m_lvl[1]) begin
      hold_t = -1;
    end else if (pr[0] || pr[1]) begin
      p_up[j] = pr[0];
      p_dn[j] = pr[1];
      hold_t  = m_cycle;
    end else if (!m_lvl[0] && !m_lvl[1]) begin
      hold_t = -1;
    end else if (hold_t >= 0) begin
      k = m_cycle - hold_t;
      if (k >= RD && ((k - RD) % RR) == 0) begin
        p_up[j] = m_lvl[0];
        p_dn[j] = m_lvl[1];
      end
    end
  endtask

  task automatic tick();
    logic [16:0] act, exp;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_edge();
    act = {ton, color_l, color_p, sel, upd};
    exp = {8'(m_ton), 3'(m_cl), 3'(m_cp), 2'(m_sel), m_upd};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle_model @%0t: {ton,cl,cp,sel,upd} got %h, expected %h", $time, act, exp);
    end
  endtask

  task automatic release_and_settle(input int n);
    btn_up = 0; btn_down = 0; btn_mode = 0;
    repeat (n) tick();
  endtask

  typedef struct {
    bit up, dn, md;
    int hold;
    int e_ton, e_cl, e_cp, e_sel, e_upd;
  } vec_t;

  vec_t tbl [15];

  int first_upd, nupd, idx;
  int exp_e [5];
  int exp_v [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    btn_up = 0; btn_down = 0; btn_mode = 0;
    reset  = 1;
    model_reset();

    //            up dn md hold  ton   cl cp sel upd
    tbl[0]  = '{0, 0, 1,    8, 'hA5, 0, 7, 1,  0};
    tbl[1]  = '{0, 0, 1,    8, 'hA5, 0, 7, 2,  0};
    tbl[2]  = '{1, 0, 0,   10, 'hA5, 0, 3, 2,  1};
    tbl[3]  = '{1, 0, 0,  100, 'hA5, 0, 7, 2,  4};
    tbl[4]  = '{1, 1, 0,   10, 'hA5, 0, 7, 2,  0};
    tbl[5]  = '{0, 0, 1,    8, 'hA5, 0, 7, 0,  0};
    tbl[6]  = '{1, 0, 0, 1000, 'hFF, 0, 7, 0, 90};
    tbl[7]  = '{1, 0, 0,   10, 'hFF, 0, 7, 0,  0};
    tbl[8]  = '{1, 1, 0,   10, 'hFF, 0, 7, 0,  0};
    tbl[9]  = '{0, 0, 1,    8, 'hFF, 0, 7, 1,  0};
    tbl[10] = '{0, 0, 1,    8, 'hFF, 0, 7, 2,  0};
    tbl[11] = '{0, 0, 1,    8, 'hFF, 0, 7, 0,  0};
    tbl[12] = '{0, 1, 1,   10, 'hFF, 0, 7, 1,  0};
    tbl[13] = '{0, 1, 0,   10, 'hFF, 0, 7, 1,  0};
    tbl[14] = '{1, 0, 0,   10, 'hFF, 1, 7, 1,  1};

    // Reset for one cycle and check reset values
    tick();
    reset = 0;
    chk("reset_ton", int'(ton), 'hA4);
    chk("reset_color_l", int'(color_l), 0);
    chk("reset_color_p", int'(color_p), 7);
    chk("reset_sel", int'(sel), 0);
    chk("reset_upd", int'(upd), 0);

    // Up held 10 cycles: exactly one step, strobe at DB+4 after the raw edge
    btn_up = 1; first_upd = -1; nupd = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) btn_up = 0;
      tick();
      if (i == DB + 3) chk("up_before_step_ton", int'(ton), 'hA4);
      if (upd) begin
        nupd++;
        if (first_upd < 0) first_upd = i;
      end
    end
    chk("up_single_upd_count", nupd, 1);
    chk("up_upd_latency", first_upd, DB + 4);
    chk("up_ton_after", int'(ton), 'hA5);

    // Glitch shorter than the debounce window
    btn_up = 1; nupd = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 4) btn_up = 0;
      tick();
      if (upd) nupd++;
    end
    chk("glitch_upd_count", nupd, 0);
    chk("glitch_ton", int'(ton), 'hA5);

    // Two mode presses to COLOR_P
    for (int i = 0; i < 2; i++) begin
      btn_mode = tbl[i].md; btn_up = tbl[i].up; btn_down = tbl[i].dn;
      repeat (tbl[i].hold) tick();
      release_and_settle(30);
      chk($sformatf("vec%0d_sel", i), int'(sel), tbl[i].e_sel);
    end

    // Down held 60 cycles: press step then auto-repeat at +32, +40, +48, +56
    exp_e = '{8, 40, 48, 56, 64};
    exp_v = '{6, 5, 4, 3, 2};
    btn_down = 1; idx = 0;
    for (int i = 1; i <= 90; i++) begin
      if (i == 61) btn_down = 0;
      tick();
      if (upd) begin
        if (idx < 5) begin
          chk($sformatf("repeat%0d_edge", idx), i, exp_e[idx]);
          chk($sformatf("repeat%0d_color_p", idx), int'(color_p), exp_v[idx]);
        end
        idx++;
      end
    end
    chk("repeat_step_count", idx, 5);

    // Table of button actions with final states and strobe counts
    for (int i = 2; i < 15; i++) begin
      btn_up = tbl[i].up; btn_down = tbl[i].dn; btn_mode = tbl[i].md;
      nupd = 0;
      for (int c = 0; c < tbl[i].hold; c++) begin
        tick();
        if (upd) nupd++;
      end
      btn_up = 0; btn_down = 0; btn_mode = 0;
      for (int c = 0; c < 30; c++) begin
        tick();
        if (upd) nupd++;
      end
      chk($sformatf("vec%0d_ton", i), int'(ton), tbl[i].e_ton);
      chk($sformatf("vec%0d_color_l", i), int'(color_l), tbl[i].e_cl);
      chk($sformatf("vec%0d_color_p", i), int'(color_p), tbl[i].e_cp);
      chk($sformatf("vec%0d_sel", i), int'(sel), tbl[i].e_sel);
      chk($sformatf("vec%0d_upd_count", i), nupd, tbl[i].e_upd);
    end

    // Randomized button activity checked every cycle by the model
    for (int s = 0; s < 80; s++) begin
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 2) == 0);
      btn_mode = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 70)) tick();
    end
    release_and_settle(20);

    // Button held through reset: one press after release, update at DB+4
    btn_up = 1;
    reset  = 1;
    repeat (3) tick();
    reset = 0;
    first_upd = -1; nupd = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (upd) begin
        nupd++;
        if (first_upd < 0) first_upd = i;
      end
    end
    chk("held_reset_upd_edge", first_upd, DB + 4);
    chk("held_reset_upd_count", nupd, 1);
    chk("held_reset_ton", int'(ton), 'hA5);
    release_and_settle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
